// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller owning the PC.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter int BITS_FOR_INSTRUCTIONS = 5,
    parameter int INSTR_WIDTH           = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             imem_ready,
    input  logic [INSTR_WIDTH-1:0]           imem_data,
    input  logic                             zero_flag,
    output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
    output logic [INSTR_WIDTH-1:0]           ir,
    output logic                             alu_en,
    output logic                             reg_write_en,
    output logic                             busy,
    output logic                             halted,
    output logic [15:0]                      retired_count
);

    localparam logic [2:0]  c_OP_ALU  = 3'b001;
    localparam logic [2:0]  c_OP_JMP  = 3'b010;
    localparam logic [2:0]  c_OP_BEQZ = 3'b011;
    localparam logic [2:0]  c_OP_HALT = 3'b111;
    localparam logic [15:0] c_RET_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t                           r_state;
    logic [BITS_FOR_INSTRUCTIONS-1:0] r_pc;
    logic [INSTR_WIDTH-1:0]           r_ir;
    logic                             r_alu_en;
    logic                             r_reg_write_en;
    logic                             r_busy;
    logic                             r_halted;
    logic [15:0]                      r_retired;

    logic [2:0]                       w_opcode;
    logic [BITS_FOR_INSTRUCTIONS-1:0] w_target;
    logic [BITS_FOR_INSTRUCTIONS-1:0] w_pc_inc;
    logic [15:0]                      w_retired_next;

    assign w_opcode       = r_ir[INSTR_WIDTH-1 -: 3];
    assign w_target       = r_ir[BITS_FOR_INSTRUCTIONS-1:0];
    // Natural width truncation gives the modulo-2^N PC wrap.
    assign w_pc_inc       = r_pc + 1'b1;
    assign w_retired_next = (r_retired == c_RET_MAX) ? r_retired : r_retired + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_ir           <= '0;
            r_alu_en       <= 1'b0;
            r_reg_write_en <= 1'b0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
            r_retired      <= 16'd0;
        end else begin
            // Enables are single-cycle pulses; only the states below raise them.
            r_alu_en       <= 1'b0;
            r_reg_write_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state  <= S_EXECUTE;
                    r_alu_en <= (w_opcode == c_OP_ALU);
                end
                S_EXECUTE: begin
                    case (w_opcode)
                        c_OP_ALU: begin
                            r_state        <= S_WRITEBACK;
                            r_reg_write_en <= 1'b1;
                        end
                        c_OP_JMP: begin
                            r_pc      <= w_target;
                            r_retired <= w_retired_next;
                            r_state   <= S_FETCH;
                        end
                        c_OP_BEQZ: begin
                            r_pc      <= zero_flag ? w_target : w_pc_inc;
                            r_retired <= w_retired_next;
                            r_state   <= S_FETCH;
                        end
                        c_OP_HALT: begin
                            r_retired <= w_retired_next;
                            r_state   <= S_HALT;
                            r_busy    <= 1'b0;
                            r_halted  <= 1'b1;
                        end
                        default: begin
                            r_pc      <= w_pc_inc;
                            r_retired <= w_retired_next;
                            r_state   <= S_FETCH;
                        end
                    endcase
                end
                S_WRITEBACK: begin
                    r_pc      <= w_pc_inc;
                    r_retired <= w_retired_next;
                    r_state   <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign instruction_address = r_pc;
    assign ir                  = r_ir;
    assign alu_en              = r_alu_en;
    assign reg_write_en        = r_reg_write_en;
    assign busy                = r_busy;
    assign halted              = r_halted;
    assign retired_count       = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_sequencer
// Brief    : Self-checking bench: directed table, corner sequences, random programs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_data;
    logic        zero_flag = 1'b0;
    logic [4:0]  instruction_address;
    logic [15:0] ir;
    logic        alu_en;
    logic        reg_write_en;
    logic        busy;
    logic        halted;
    logic [15:0] retired_count;

    logic [15:0] mem [32];
    logic [15:0] ret_exp;
    int          tests = 0;
    int          failures = 0;

    localparam logic [2:0] c_NOP = 3'b000, c_ALU = 3'b001, c_JMP = 3'b010,
                           c_BEQZ = 3'b011, c_HALT = 3'b111;

    assign imem_data = mem[instruction_address];

    instruction_sequencer #(.BITS_FOR_INSTRUCTIONS(5), .INSTR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_ready(imem_ready),
        .imem_data(imem_data), .zero_flag(zero_flag),
        .instruction_address(instruction_address), .ir(ir), .alu_en(alu_en),
        .reg_write_en(reg_write_en), .busy(busy), .halted(halted),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] pc;
        logic [2:0] op;
        logic [4:0] tgt;
        logic       zf;
        logic [4:0] exp_next;
        logic       exp_alu;
        logic       exp_halt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [4:0] tgt);
        return {op, 8'h00, tgt};
    endfunction

    // Instruction-level reference: next PC from opcode rules, modulo 32.
    function automatic logic [4:0] model_next(input logic [4:0] pc, input logic [15:0] w,
                                              input logic zf);
        logic [2:0] op;
        int         p;
        op = w[15:13];
        p  = int'(pc);
        case (op)
            c_JMP:   return w[4:0];
            c_BEQZ:  return zf ? w[4:0] : 5'((p + 1) % 32);
            c_HALT:  return pc;
            default: return 5'((p + 1) % 32);
        endcase
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = enc(c_NOP, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        imem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        ret_exp = 16'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Entered one step after an edge with the DUT in FETCH; leaves it likewise.
    task automatic exec_one(input logic [4:0] e_pc, input logic [15:0] e_ir, input logic e_alu,
                            input logic [4:0] e_next, input logic e_halt, input logic zf,
                            input int stalls);
        logic [15:0] ir_before;
        ir_before = ir;
        zero_flag = zf;
        for (int s = 0; s < stalls; s++) begin
            imem_ready = 1'b0;
            @(posedge clk); #1;
            check("stall_ir", 32'(ir), 32'(ir_before));
            check("stall_pc", 32'(instruction_address), 32'(e_pc));
            check("stall_busy", 32'(busy), 32'd1);
        end
        check("fetch_addr", 32'(instruction_address), 32'(e_pc));
        imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        check("decode_ir", 32'(ir), 32'(e_ir));
        check("decode_alu_en", 32'(alu_en), 32'd0);
        @(posedge clk); #1;
        check("exec_alu_en", 32'(alu_en), 32'(e_alu));
        check("exec_rwe", 32'(reg_write_en), 32'd0);
        @(posedge clk); #1;
        if (e_alu) begin
            check("wb_rwe", 32'(reg_write_en), 32'd1);
            check("wb_alu_en", 32'(alu_en), 32'd0);
            check("wb_pc", 32'(instruction_address), 32'(e_pc));
            @(posedge clk); #1;
        end
        if (ret_exp != 16'hFFFF) ret_exp = ret_exp + 16'd1;
        check("retired", 32'(retired_count), 32'(ret_exp));
        check("next_addr", 32'(instruction_address), 32'(e_next));
        check("halted", 32'(halted), 32'(e_halt));
        check("busy", 32'(busy), 32'(!e_halt));
        check("post_rwe", 32'(reg_write_en), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, 32'(instruction_address), 32'd0);
        check({tag, "_ir"}, 32'(ir), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_retired"}, 32'(retired_count), 32'd0);
        check({tag, "_en"}, 32'({alu_en, reg_write_en}), 32'd0);
    endtask

    initial begin
        int n, alu_cyc, rwe_cyc, halt_cyc, alu_cnt, rwe_cnt;
        logic [4:0]  pc;
        logic [15:0] w;
        logic        zf;

        vecs[0] = '{5'd0,  c_BEQZ, 5'd5,  1'b1, 5'd5,  1'b0, 1'b0};
        vecs[1] = '{5'd0,  c_BEQZ, 5'd5,  1'b0, 5'd1,  1'b0, 1'b0};
        vecs[2] = '{5'd31, c_JMP,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
        vecs[3] = '{5'd31, c_NOP,  5'd9,  1'b1, 5'd0,  1'b0, 1'b0};
        vecs[4] = '{5'd7,  c_ALU,  5'd3,  1'b0, 5'd8,  1'b1, 1'b0};
        vecs[5] = '{5'd12, 3'b101, 5'd2,  1'b1, 5'd13, 1'b0, 1'b0};
        vecs[6] = '{5'd9,  c_HALT, 5'd1,  1'b0, 5'd9,  1'b0, 1'b1};
        vecs[7] = '{5'd20, c_BEQZ, 5'd20, 1'b1, 5'd20, 1'b0, 1'b0};
        vecs[8] = '{5'd31, c_ALU,  5'd0,  1'b0, 5'd0,  1'b1, 1'b0};

        clear_mem();
        do_reset();

        // Idle after reset with start low.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("idle_pc", 32'(instruction_address), 32'd0);
            check("idle_busy", 32'({busy, alu_en, reg_write_en, halted}), 32'd0);
        end
        check("idle_retired", 32'(retired_count), 32'd0);

        // Directed table.
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            do_reset();
            if (vecs[v].pc != 5'd0) mem[0] = enc(c_JMP, vecs[v].pc);
            mem[vecs[v].pc] = enc(vecs[v].op, vecs[v].tgt);
            do_start();
            if (vecs[v].pc != 5'd0) exec_one(5'd0, mem[0], 1'b0, vecs[v].pc, 1'b0, 1'b0, 0);
            exec_one(vecs[v].pc, mem[vecs[v].pc], vecs[v].exp_alu, vecs[v].exp_next,
                     vecs[v].exp_halt, vecs[v].zf, 1);
        end

        // Straight-line program timing.
        clear_mem();
        mem[0] = enc(c_NOP, 5'd0);
        mem[1] = enc(c_ALU, 5'd0);
        mem[2] = enc(c_NOP, 5'd0);
        mem[3] = enc(c_HALT, 5'd0);
        do_reset();
        imem_ready = 1'b1;
        do_start();
        alu_cyc = -1; rwe_cyc = -1; halt_cyc = -1; alu_cnt = 0; rwe_cnt = 0;
        for (n = 1; n <= 30 && halt_cyc < 0; n++) begin
            @(posedge clk); #1;
            if (alu_en) begin alu_cnt++; alu_cyc = n; end
            if (reg_write_en) begin rwe_cnt++; rwe_cyc = n; end
            if (halted) halt_cyc = n;
        end
        check("sl_halt_cycle", 32'(halt_cyc), 32'd13);
        check("sl_alu_cycle", 32'(alu_cyc), 32'd5);
        check("sl_rwe_cycle", 32'(rwe_cyc), 32'd6);
        check("sl_en_counts", 32'(alu_cnt * 16 + rwe_cnt), 32'h11);
        check("sl_pc", 32'(instruction_address), 32'd3);
        check("sl_retired", 32'(retired_count), 32'd4);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("halt_absorb", 32'({halted, busy}), 32'b10);
        check("halt_pc_hold", 32'(instruction_address), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("rst_halt");

        // Stall with ALU at 0: alu_en one edge after DECODE entry.
        clear_mem();
        mem[0] = enc(c_ALU, 5'd0);
        do_reset();
        do_start();
        exec_one(5'd0, mem[0], 1'b1, 5'd1, 1'b0, 1'b0, 4);

        // Reset in the middle of a fetch stall, then restart from 0.
        clear_mem();
        mem[0] = enc(c_JMP, 5'd6);
        do_reset();
        do_start();
        exec_one(5'd0, mem[0], 1'b0, 5'd6, 1'b0, 1'b0, 0);
        imem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check_reset_state("rst_stall");
        @(posedge clk); #1;
        check("idle_after_rst", 32'(busy), 32'd0);
        ret_exp = 16'd0;
        do_start();
        exec_one(5'd0, mem[0], 1'b0, 5'd6, 1'b0, 1'b0, 0);

        // Retirement counter saturation.
        clear_mem();
        mem[0] = enc(c_JMP, 5'd0);
        do_reset();
        do_start();
        exec_one(5'd0, mem[0], 1'b0, 5'd0, 1'b0, 1'b0, 0);
        force dut.r_retired = 16'hFFFE;
        #1;
        release dut.r_retired;
        ret_exp = 16'hFFFE;
        for (int k = 0; k < 3; k++) exec_one(5'd0, mem[0], 1'b0, 5'd0, 1'b0, 1'b0, 0);
        check("sat_value", 32'(retired_count), 32'hFFFF);

        // Random programs against the instruction-level model.
        for (int prog = 0; prog < 6; prog++) begin
            for (int i = 0; i < 32; i++) begin
                w = 16'($urandom);
                if (w[15:13] == c_HALT && $urandom_range(0, 3) != 0) w[15:13] = c_NOP;
                mem[i] = w;
            end
            do_reset();
            do_start();
            pc = 5'd0;
            for (int k = 0; k < 40; k++) begin
                w  = mem[pc];
                zf = 1'($urandom_range(0, 1));
                exec_one(pc, w, w[15:13] == c_ALU, model_next(pc, w, zf),
                         w[15:13] == c_HALT, zf, $urandom_range(0, 3));
                if (w[15:13] == c_HALT) break;
                pc = model_next(pc, w, zf);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
